// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arb #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [2:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  logic [2:0]     req1_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*N-1:0] rsp0_data,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*N-1:0] rsp1_data,
    output logic [N-1:0]   alu_x,
    output logic [N-1:0]   alu_y,
    output logic [2:0]     alu_sel,
    input  logic [2*N-1:0] alu_out,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state_reg, state_next;
    logic [N-1:0] a_reg, b_reg;
    logic [2:0]   op_reg;
    logic         owner_reg;

    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic         any_valid, grant, accept, rsp_done;
    logic [N-1:0] sel_a, sel_b;
    logic [2:0]   sel_op;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign any_valid = |req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = ~req_valid[0];
`else
    logic last_grant_reg;

    // On a tie, favour whoever was not served last.
    always_comb begin
        grant = ~req_valid[0];
        if (&req_valid) begin
            grant = ~last_grant_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (rsp_done) begin
            last_grant_reg <= owner_reg;
        end
    end
`endif

    assign accept   = |(req_valid & req_ready);
    assign rsp_done = (state_reg == RESP) && rsp_ready[owner_reg];
    assign sel_a    = grant ? req1_a  : req0_a;
    assign sel_b    = grant ? req1_b  : req0_b;
    assign sel_op   = grant ? req1_op : req0_op;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= sel_a;
                b_reg     <= sel_b;
                op_reg    <= sel_op;
                owner_reg <= grant;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [2*N-1:0] data_reg;

            // Ready is gated by rst_n so it reads 0 while reset is held.
            assign req_ready[gi] = rst_n && (state_reg == IDLE) && any_valid && (grant == 1'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if ((state_reg == EXEC) && (owner_reg == 1'(gi))) begin
                    data_reg <= alu_out;
                end
            end
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = g_req[0].data_reg;
    assign rsp1_data  = g_req[1].data_reg;
    assign alu_x      = a_reg;
    assign alu_y      = b_reg;
    assign alu_sel    = op_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: stimulus queues expected responses, a negedge monitor checks them.
// Stub ALU concatenates its operands so every response identifies its operation.
module tb_alu_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [2:0]     req0_op, req1_op;
    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready, rsp1_ready;
    logic [2*N-1:0] rsp0_data, rsp1_data;
    logic [N-1:0]   alu_x, alu_y;
    logic [2:0]     alu_sel;
    logic [2*N-1:0] alu_out;
    logic           busy;

    always #5 clk = ~clk;

    assign alu_out = {alu_x, alu_y};

    alu_arb #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy)
    );

    typedef struct packed {
        logic       owner;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic track_r1 = 1'b0;
    logic req1_ready_seen = 1'b0;
    logic mon_v, mon_r;
    logic [7:0] mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [7:0] data);
        sb_q.push_back({owner, data});
    endtask

    // Monitor: every response handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (track_r1 && req1_ready) req1_ready_seen = 1'b1;
            if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 1, 0);
            for (int k = 0; k < 2; k++) begin
                mon_v = (k == 0) ? rsp0_valid : rsp1_valid;
                mon_r = (k == 0) ? rsp0_ready : rsp1_ready;
                mon_d = (k == 0) ? rsp0_data  : rsp1_data;
                if (mon_v && mon_r) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: owner %0d data %h, required no response", k, mon_d);
                    end else begin
                        mon_e = sb_q.pop_front();
                        $display("rsp owner=%0d data=%h (expected owner=%0d data=%h)",
                                 k, mon_d, mon_e.owner, mon_e.data);
                        chk("rsp_owner", k, 32'(mon_e.owner));
                        chk("rsp_data", 32'(mon_d), 32'(mon_e.data));
                    end
                end
            end
        end
    end

    // Returns just after the accepting edge.
    task automatic wait_ready(input int k);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((k == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(got), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic check_zero();
        chk("zero_req0_ready", 32'(req0_ready), 0);
        chk("zero_req1_ready", 32'(req1_ready), 0);
        chk("zero_rsp0_valid", 32'(rsp0_valid), 0);
        chk("zero_rsp1_valid", 32'(rsp1_valid), 0);
        chk("zero_rsp0_data", 32'(rsp0_data), 0);
        chk("zero_rsp1_data", 32'(rsp1_data), 0);
        chk("zero_alu_x", 32'(alu_x), 0);
        chk("zero_alu_y", 32'(alu_y), 0);
        chk("zero_alu_sel", 32'(alu_sel), 0);
        chk("zero_busy", 32'(busy), 0);
    endtask

    logic rose;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_zero();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request: operands reach the ALU in EXEC, response one cycle later.
        req0_a = 4'b0110; req0_b = 4'b0011; req0_op = 3'b001; req0_valid = 1'b1;
        push_exp(1'b0, 8'b0110_0011);
        wait_ready(0);
        req0_valid = 1'b0;
        chk("exec_alu_sel", 32'(alu_sel), 32'h1);
        chk("exec_alu_x", 32'(alu_x), 32'h6);
        chk("exec_alu_y", 32'(alu_y), 32'h3);
        chk("exec_busy", 32'(busy), 1);
        chk("exec_rsp0_valid", 32'(rsp0_valid), 0);
        chk("exec_req0_ready", 32'(req0_ready), 0);
        @(posedge clk);
        #1;
        chk("resp_rsp0_valid", 32'(rsp0_valid), 1);
        chk("resp_rsp0_data", 32'(rsp0_data), 32'h63);
        chk("resp_rsp1_valid", 32'(rsp1_valid), 0);
        wait_drain();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_alu_sel_hold", 32'(alu_sel), 32'h1);

        // Arbitration: both valid straight out of reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        req0_a = 4'h1; req0_b = 4'h2; req0_op = 3'd3; req0_valid = 1'b1;
        req1_a = 4'h5; req1_b = 4'h9; req1_op = 3'd4; req1_valid = 1'b1;
        #1;
        chk("rst_req0_ready_gated", 32'(req0_ready), 0);
        chk("rst_req1_ready_gated", 32'(req1_ready), 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 8'h12);
`else
        push_exp(1'b0, 8'h12);
        push_exp(1'b1, 8'h59);
        push_exp(1'b0, 8'h12);
        push_exp(1'b1, 8'h59);
`endif
        track_r1 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        track_r1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("req1_ready_seen", 32'(req1_ready_seen), 0);
`else
        chk("req1_ready_seen", 32'(req1_ready_seen), 1);
`endif

        // Backpressure on requester 1 while requester 0 waits.
        rsp1_ready = 1'b0;
        req1_a = 4'hA; req1_b = 4'hC; req1_op = 3'b111; req1_valid = 1'b1;
        push_exp(1'b1, 8'hAC);
        push_exp(1'b0, 8'h3E);
        wait_ready(1);
        req1_valid = 1'b0;
        req0_a = 4'h3; req0_b = 4'hE; req0_op = 3'd0; req0_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
            chk("bp_rsp1_data", 32'(rsp1_data), 32'hAC);
            chk("bp_req0_ready", 32'(req0_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_rsp0_valid", 32'(rsp0_valid), 0);
            @(posedge clk);
            #1;
        end
        rsp1_ready = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        wait_drain();

        // Abort: reset during EXEC discards the operation.
        req0_a = 4'hF; req0_b = 4'h1; req0_op = 3'd2; req0_valid = 1'b1;
        wait_ready(0);
        req0_valid = 1'b0;
        chk("abort_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp0_valid) rose = 1'b1;
        end
        chk("abort_no_rsp", 32'(rose), 0);
        @(posedge clk);
        #1;
        req0_a = 4'h2; req0_b = 4'h5; req0_op = 3'd6; req0_valid = 1'b1;
        push_exp(1'b0, 8'h25);
        wait_ready(0);
        req0_valid = 1'b0;
        wait_drain();

        chk("final_queue_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
